// File: rtl/amp_spi_sequencer.sv
// Autonomous mode-3 SPI master for the eight amplifier/VGA control buses.
// It broadcasts one word to the selected channels/chips and captures readback from the lowest selected channel.
module amp_spi_sequencer #(
  parameter int CLK_DIV   = 4,
  parameter int WORD_BITS = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start,
  input  logic [7:0]           chan_mask,
  input  logic [2:0]           chip_sel,
  input  logic [WORD_BITS-1:0] tx_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WORD_BITS-1:0] rx_data,
  output logic [7:0]           spi_sclk,
  output logic [7:0]           spi_mosi,
  input  logic [7:0]           spi_miso,
  output logic [23:0]          spi_csn
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(WORD_BITS + 1);
  localparam logic [CW-1:0] CNT_LOAD  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BITS_LOAD = BW'(WORD_BITS);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bits_left;
  logic [7:0]           ch_mask;
  logic [WORD_BITS-1:0] tx_shift;
  logic [WORD_BITS-1:0] rx_shift;
  logic [23:0]          csn_sel;
  logic [2:0]           miso_idx;
  logic                 phase_end;

  assign phase_end = (cnt == '0);

  // Chip selects driven low for a new request: chip k of channel n only when both are selected.
  always_comb begin
    csn_sel = '1;
    for (int n = 0; n < 8; n++)
      for (int k = 0; k < 3; k++)
        csn_sel[3*n+k] = ~(chan_mask[n] & chip_sel[k]);
  end

  always_comb begin
    miso_idx = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (ch_mask[i]) miso_idx = 3'(i);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      bits_left <= '0;
      ch_mask   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rx_data   <= '0;
      spi_sclk  <= 8'hFF;
      spi_mosi  <= 8'hFF;
      spi_csn   <= '1;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state != IDLE)
        cnt <= phase_end ? CNT_LOAD : cnt - 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            if (chan_mask != 8'h00 && chip_sel != 3'b000) begin
              state     <= SETUP;
              busy      <= 1'b1;
              cnt       <= CNT_LOAD;
              bits_left <= BITS_LOAD;
              ch_mask   <= chan_mask;
              tx_shift  <= tx_data;
              spi_csn   <= csn_sel;
              spi_mosi  <= ~chan_mask | {8{tx_data[WORD_BITS-1]}};
            end else begin
              done <= 1'b1;
              err  <= 1'b1;
            end
          end
        end
        SETUP, HIGH: begin
          if (phase_end) begin
            if (state == HIGH && bits_left == '0) begin
              state <= HOLD;
            end else begin
              // Falling edge: present the next bit only on selected channels.
              state    <= LOW;
              spi_sclk <= ~ch_mask;
              spi_mosi <= ~ch_mask | {8{tx_shift[WORD_BITS-1]}};
              tx_shift <= tx_shift << 1;
            end
          end
        end
        LOW: begin
          if (phase_end) begin
            state     <= HIGH;
            spi_sclk  <= 8'hFF;
            bits_left <= bits_left - 1'b1;
            rx_shift  <= {rx_shift[WORD_BITS-2:0], spi_miso[miso_idx]};
          end
        end
        HOLD: begin
          if (phase_end) begin
            state    <= GAP;
            spi_csn  <= '1;
            spi_mosi <= 8'hFF;
          end
        end
        GAP: begin
          if (phase_end) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_shift;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amp_spi_sequencer.sv
// Directed bench for amp_spi_sequencer at CLK_DIV 4, 1 and 7.
module tb_amp_spi_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [2:0]  start_v = 3'b000;
  logic [7:0]  chan_mask = 8'h00;
  logic [2:0]  chip_sel = 3'b000;
  logic [15:0] tx_data = 16'h0000;
  logic [7:0]  spi_miso = 8'hFF;

  logic [2:0]  busy_v, done_v, err_v;
  logic [15:0] rx_v   [3];
  logic [7:0]  sclk_v [3];
  logic [7:0]  mosi_v [3];
  logic [23:0] csn_v  [3];

  amp_spi_sequencer #(.CLK_DIV(4), .WORD_BITS(16)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start_v[0]), .chan_mask(chan_mask),
    .chip_sel(chip_sel), .tx_data(tx_data), .busy(busy_v[0]), .done(done_v[0]),
    .err(err_v[0]), .rx_data(rx_v[0]), .spi_sclk(sclk_v[0]), .spi_mosi(mosi_v[0]),
    .spi_miso(spi_miso), .spi_csn(csn_v[0]));

  amp_spi_sequencer #(.CLK_DIV(1), .WORD_BITS(16)) u_dut_d1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start_v[1]), .chan_mask(chan_mask),
    .chip_sel(chip_sel), .tx_data(tx_data), .busy(busy_v[1]), .done(done_v[1]),
    .err(err_v[1]), .rx_data(rx_v[1]), .spi_sclk(sclk_v[1]), .spi_mosi(mosi_v[1]),
    .spi_miso(spi_miso), .spi_csn(csn_v[1]));

  amp_spi_sequencer #(.CLK_DIV(7), .WORD_BITS(16)) u_dut_d7 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start_v[2]), .chan_mask(chan_mask),
    .chip_sel(chip_sel), .tx_data(tx_data), .busy(busy_v[2]), .done(done_v[2]),
    .err(err_v[2]), .rx_data(rx_v[2]), .spi_sclk(sclk_v[2]), .spi_mosi(mosi_v[2]),
    .spi_miso(spi_miso), .spi_csn(csn_v[2]));

  int sel = 0;
  logic        m_busy, m_done, m_err;
  logic [15:0] m_rx;
  logic [7:0]  m_sclk, m_mosi;
  logic [23:0] m_csn;
  assign m_busy = busy_v[sel];
  assign m_done = done_v[sel];
  assign m_err  = err_v[sel];
  assign m_rx   = rx_v[sel];
  assign m_sclk = sclk_v[sel];
  assign m_mosi = mosi_v[sel];
  assign m_csn  = csn_v[sel];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int first_low_cyc = 0;
  int last_low_cyc = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a clock edge; returns #1 after the edge that accepted start.
  task automatic applyStimulus(input logic [7:0] mask, input logic [2:0] chips, input logic [15:0] data);
    chan_mask = mask;
    chip_sel = chips;
    tx_data = data;
    start_v[sel] = 1'b1;
    @(posedge clk); #1;
    start_v = 3'b000;
  endtask

  task automatic watch_xfer(input string tag, input int d, input logic [7:0] mask,
                            input logic [2:0] chips, input logic [15:0] data,
                            input logic [15:0] rx_exp, input logic drive_miso,
                            input logic disturb);
    int busy_cnt = 0;
    int rise = 0;
    int fall = 0;
    int viol = 0;
    int ch = 0;
    logic [15:0] word = 16'h0000;
    logic [7:0]  prev_sclk = 8'hFF;
    logic [23:0] exp_csn = '1;
    for (int i = 7; i >= 0; i--) if (mask[i]) ch = i;
    for (int n = 0; n < 8; n++)
      for (int k = 0; k < 3; k++)
        if (mask[n] && chips[k]) exp_csn[3*n+k] = 1'b0;
    first_low_cyc = cyc;
    checkOutput({tag, "_busy_rise"}, {31'd0, m_busy}, 32'd1);
    checkOutput({tag, "_csn_low"}, {8'd0, m_csn}, {8'd0, exp_csn});
    for (int k = 0; k < 4000; k++) begin
      if (m_busy !== 1'b1) break;
      busy_cnt++;
      if ((m_sclk & ~mask) !== ~mask || (m_mosi & ~mask) !== ~mask) viol++;
      if ((m_sclk & mask) !== 8'h00 && (m_sclk & mask) !== mask) viol++;
      if (m_csn !== 24'hFFFFFF && m_csn !== exp_csn) viol++;
      if (m_done !== 1'b0) viol++;
      if (m_csn === exp_csn) last_low_cyc = cyc;
      if (prev_sclk[ch] === 1'b1 && m_sclk[ch] === 1'b0) begin
        if (drive_miso) begin
          spi_miso[4] = rx_exp[15-fall];
          spi_miso[5] = ~rx_exp[15-fall];
        end
        fall++;
      end
      if (prev_sclk[ch] === 1'b0 && m_sclk[ch] === 1'b1) begin
        rise++;
        word = {word[14:0], m_mosi[ch]};
      end
      prev_sclk = m_sclk;
      if (disturb && busy_cnt == 40) begin
        start_v[sel] = 1'b1;
        tx_data = 16'h0000;
        chan_mask = 8'hFF;
        chip_sel = 3'h7;
      end
      if (disturb && busy_cnt == 41) start_v = 3'b000;
      @(posedge clk); #1;
    end
    spi_miso = 8'hFF;
    checkOutput({tag, "_busy_len"}, busy_cnt, d * 35);
    checkOutput({tag, "_done"}, {31'd0, m_done}, 32'd1);
    checkOutput({tag, "_err"}, {31'd0, m_err}, 32'd0);
    checkOutput({tag, "_rises"}, rise, 16);
    checkOutput({tag, "_falls"}, fall, 16);
    checkOutput({tag, "_mosi_word"}, {16'd0, word}, {16'd0, data});
    checkOutput({tag, "_bus_viol"}, viol, 0);
    checkOutput({tag, "_rx"}, {16'd0, m_rx}, {16'd0, rx_exp});
  endtask

  initial begin
    int dones;
    int last_a;
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", {31'd0, m_busy}, 32'd0);
    checkOutput("rst_done", {31'd0, m_done}, 32'd0);
    checkOutput("rst_err", {31'd0, m_err}, 32'd0);
    checkOutput("rst_rx", {16'd0, m_rx}, 32'd0);
    checkOutput("rst_sclk", {24'd0, m_sclk}, 32'hFF);
    checkOutput("rst_mosi", {24'd0, m_mosi}, 32'hFF);
    checkOutput("rst_csn", {8'd0, m_csn}, 32'hFFFFFF);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(8'h04, 3'h2, 16'hA5C3);
    checkOutput("single_csn7", {8'd0, m_csn}, 32'hFFFF7F);
    watch_xfer("single", 4, 8'h04, 3'h2, 16'hA5C3, 16'hFFFF, 1'b0, 1'b0);

    applyStimulus(8'h30, 3'h1, 16'h1234);
    watch_xfer("readback", 4, 8'h30, 3'h1, 16'h1234, 16'h3C96, 1'b1, 1'b0);

    applyStimulus(8'hFF, 3'h7, 16'h5A0F);
    checkOutput("bcast_csn_all", {8'd0, m_csn}, 32'h000000);
    watch_xfer("bcast", 4, 8'hFF, 3'h7, 16'h5A0F, 16'hFFFF, 1'b0, 1'b0);

    applyStimulus(8'h04, 3'h0, 16'hFFFF);
    checkOutput("rej_done", {31'd0, m_done}, 32'd1);
    checkOutput("rej_err", {31'd0, m_err}, 32'd1);
    checkOutput("rej_busy", {31'd0, m_busy}, 32'd0);
    checkOutput("rej_csn", {8'd0, m_csn}, 32'hFFFFFF);
    checkOutput("rej_sclk", {24'd0, m_sclk}, 32'hFF);
    checkOutput("rej_mosi", {24'd0, m_mosi}, 32'hFF);
    checkOutput("rej_rx_kept", {16'd0, m_rx}, 32'hFFFF);
    @(posedge clk); #1;
    checkOutput("rej_done_one", {31'd0, m_done}, 32'd0);
    applyStimulus(8'h00, 3'h1, 16'h0000);
    checkOutput("rej2_done", {31'd0, m_done}, 32'd1);
    checkOutput("rej2_err", {31'd0, m_err}, 32'd1);

    applyStimulus(8'h04, 3'h2, 16'h0F0F);
    watch_xfer("overlap", 4, 8'h04, 3'h2, 16'h0F0F, 16'hFFFF, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("overlap_no_2nd_done", {31'd0, m_done}, 32'd0);
    checkOutput("overlap_idle", {31'd0, m_busy}, 32'd0);

    applyStimulus(8'h01, 3'h1, 16'h8001);
    watch_xfer("b2b_a", 4, 8'h01, 3'h1, 16'h8001, 16'hFFFF, 1'b0, 1'b0);
    last_a = last_low_cyc;
    applyStimulus(8'h01, 3'h1, 16'h7FFE);
    watch_xfer("b2b_b", 4, 8'h01, 3'h1, 16'h7FFE, 16'hFFFF, 1'b0, 1'b0);
    checkOutput("b2b_csn_gap", first_low_cyc - last_a - 1, 5);

    applyStimulus(8'h04, 3'h2, 16'hA5C3);
    repeat (70) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_busy", {31'd0, m_busy}, 32'd0);
    checkOutput("midrst_done", {31'd0, m_done}, 32'd0);
    checkOutput("midrst_err", {31'd0, m_err}, 32'd0);
    checkOutput("midrst_rx", {16'd0, m_rx}, 32'd0);
    checkOutput("midrst_sclk", {24'd0, m_sclk}, 32'hFF);
    checkOutput("midrst_mosi", {24'd0, m_mosi}, 32'hFF);
    checkOutput("midrst_csn", {8'd0, m_csn}, 32'hFFFFFF);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (m_done === 1'b1 || m_busy === 1'b1) dones++;
    end
    checkOutput("midrst_quiet", dones, 0);

    sel = 1;
    #0;
    applyStimulus(8'h04, 3'h2, 16'hA5C3);
    watch_xfer("div1", 1, 8'h04, 3'h2, 16'hA5C3, 16'hFFFF, 1'b0, 1'b0);
    sel = 2;
    #0;
    applyStimulus(8'h04, 3'h2, 16'hA5C3);
    watch_xfer("div7", 7, 8'h04, 3'h2, 16'hA5C3, 16'hFFFF, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
